perceptron_layer: RTL and testbench

Parametrised single-layer perceptron engine computing y[j] = act(sum_i W[j][i]*x[i] + b[j]) for OUT_SIZE neurons over IN_SIZE inputs.
- Holds weights, biases and the input vector in internal register files, loaded through write ports.
- Evaluates with one time-shared signed MAC, streams each neuron result out, and reports the argmax class.
- Successor to the fixed 4x2 classifier: adds bias, selectable activation, saturation and argmax.

---
 rtl/perceptron_pkg.sv | 26 ++
 rtl/perceptron_layer_mac_unit.sv | 33 +++
 rtl/perceptron_layer.sv | 209 ++++++++++++++++++++
 tb/tb_perceptron_layer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared encodings, FSM states and arithmetic helpers for the perceptron layer.
package perceptron_pkg;

  localparam logic [1:0] ACT_LINEAR = 2'd0;
  localparam logic [1:0] ACT_RELU   = 2'd1;
  localparam logic [1:0] ACT_STEP   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN, S_DONE} state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a wide signed value into a w-bit signed range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/perceptron_layer_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and enable.
module mac_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_d;
  logic signed [ACC_WIDTH-1:0]    acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + ACC_WIDTH'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/perceptron_layer.sv
// Single-layer perceptron: register files, one shared MAC, activation,
// saturation, streamed neuron results and argmax class.
module perceptron_layer
  import perceptron_pkg::*;
#(
  parameter int unsigned IN_SIZE    = 4,
  parameter int unsigned OUT_SIZE   = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      w_wen,
  input  logic [idx_w(IN_SIZE*OUT_SIZE)-1:0]        w_addr,
  input  logic signed [DATA_WIDTH-1:0]              w_data,
  input  logic                                      b_wen,
  input  logic [idx_w(OUT_SIZE)-1:0]                b_addr,
  input  logic signed [DATA_WIDTH-1:0]              b_data,
  input  logic                                      x_wen,
  input  logic [idx_w(IN_SIZE)-1:0]                 x_addr,
  input  logic signed [DATA_WIDTH-1:0]              x_data,
  input  logic [1:0]                                act_mode,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      out_valid,
  output logic [idx_w(OUT_SIZE)-1:0]                out_idx,
  output logic signed [OUT_WIDTH-1:0]               out_data,
  output logic [idx_w(OUT_SIZE)-1:0]                class_idx,
  output logic                                      done
);

  localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(IN_SIZE) + 1;
  localparam int unsigned W_NUM     = IN_SIZE * OUT_SIZE;
  localparam int unsigned WAW       = idx_w(W_NUM);
  localparam int unsigned JW        = idx_w(OUT_SIZE);
  localparam int unsigned IW        = idx_w(IN_SIZE);

  logic signed [DATA_WIDTH-1:0] w_q [W_NUM];
  logic signed [DATA_WIDTH-1:0] w_d [W_NUM];
  logic signed [DATA_WIDTH-1:0] b_q [OUT_SIZE];
  logic signed [DATA_WIDTH-1:0] b_d [OUT_SIZE];
  logic signed [DATA_WIDTH-1:0] x_q [IN_SIZE];
  logic signed [DATA_WIDTH-1:0] x_d [IN_SIZE];

  state_e                state_q, state_d;
  logic [IW-1:0]         i_q, i_d;
  logic [JW-1:0]         j_q, j_d;
  logic [1:0]            act_q, act_d;
  logic signed [OUT_WIDTH-1:0] best_q, best_d;
  logic [JW-1:0]         best_idx_q, best_idx_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [JW-1:0]         out_idx_q, out_idx_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [JW-1:0]         class_idx_q, class_idx_d;
  logic                  done_q, done_d;

  logic                  mac_clr, mac_en;
  logic [WAW-1:0]        w_idx;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [63:0]    biased;
  logic signed [OUT_WIDTH-1:0] r_sat;
  logic signed [OUT_WIDTH-1:0] act_val;

  assign w_idx = WAW'(32'(j_q) * IN_SIZE + 32'(i_q));

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (w_q[w_idx]),
    .b   (x_q[i_q]),
    .acc (acc)
  );

  // Bias add, saturation and activation of the finished neuron.
  always_comb begin
    biased  = 64'(acc) + 64'(b_q[j_q]);
    r_sat   = OUT_WIDTH'(saturate(biased, OUT_WIDTH));
    act_val = r_sat;
    case (act_q)
      ACT_RELU: if (r_sat[OUT_WIDTH-1]) act_val = '0;
      ACT_STEP: act_val = (!r_sat[OUT_WIDTH-1] && (r_sat != '0)) ? OUT_WIDTH'(1) : '0;
      default:  act_val = r_sat;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    act_d       = act_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    class_idx_d = class_idx_q;
    done_d      = 1'b0;
    w_d         = w_q;
    b_d         = b_q;
    x_d         = x_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;

    if (state_q == S_IDLE) begin
      if (w_wen && (32'(w_addr) < W_NUM))    w_d[w_addr] = w_data;
      if (b_wen && (32'(b_addr) < OUT_SIZE)) b_d[b_addr] = b_data;
      if (x_wen && (32'(x_addr) < IN_SIZE))  x_d[x_addr] = x_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_MAC;
          act_d      = act_mode;
          i_d        = '0;
          j_d        = '0;
          best_d     = '0;
          best_idx_d = '0;
          busy_d     = 1'b1;
          mac_clr    = 1'b1;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (32'(i_q) == IN_SIZE - 1) begin
          i_d     = '0;
          state_d = S_FIN;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_FIN: begin
        out_valid_d = 1'b1;
        out_idx_d   = j_q;
        out_data_d  = act_val;
        mac_clr     = 1'b1;
        // Strict compare: ties keep the lower index.
        if ((j_q == '0) || (act_val > best_q)) begin
          best_d     = act_val;
          best_idx_d = j_q;
        end
        if (32'(j_q) == OUT_SIZE - 1) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        class_idx_d = best_idx_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      act_q       <= ACT_LINEAR;
      best_q      <= '0;
      best_idx_q  <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      class_idx_q <= '0;
      done_q      <= 1'b0;
      w_q         <= '{default: '0};
      b_q         <= '{default: '0};
      x_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      act_q       <= act_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      class_idx_q <= class_idx_d;
      done_q      <= done_d;
      w_q         <= w_d;
      b_q         <= b_d;
      x_q         <= x_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign class_idx = class_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_perceptron_layer.sv
// Directed bench for perceptron_layer: a 4x2 instance and a 3x5 instance.
module tb_perceptron_layer;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-input, 2-neuron instance
  logic              a_w_wen, a_b_wen, a_x_wen, a_start;
  logic [2:0]        a_w_addr;
  logic [0:0]        a_b_addr;
  logic [1:0]        a_x_addr;
  logic signed [7:0] a_w_data, a_b_data, a_x_data;
  logic [1:0]        a_act;
  logic              a_busy, a_out_valid, a_done;
  logic [0:0]        a_out_idx, a_class;
  logic signed [15:0] a_out_data;

  // 3-input, 5-neuron instance
  logic              p_w_wen, p_b_wen, p_x_wen, p_start;
  logic [3:0]        p_w_addr;
  logic [2:0]        p_b_addr;
  logic [1:0]        p_x_addr;
  logic signed [7:0] p_w_data, p_b_data, p_x_data;
  logic [1:0]        p_act;
  logic              p_busy, p_out_valid, p_done;
  logic [2:0]        p_out_idx, p_class;
  logic signed [15:0] p_out_data;

  perceptron_layer dut (
    .clk(clk), .rst(rst),
    .w_wen(a_w_wen), .w_addr(a_w_addr), .w_data(a_w_data),
    .b_wen(a_b_wen), .b_addr(a_b_addr), .b_data(a_b_data),
    .x_wen(a_x_wen), .x_addr(a_x_addr), .x_data(a_x_data),
    .act_mode(a_act), .start(a_start),
    .busy(a_busy), .out_valid(a_out_valid), .out_idx(a_out_idx),
    .out_data(a_out_data), .class_idx(a_class), .done(a_done)
  );

  perceptron_layer #(.IN_SIZE(3), .OUT_SIZE(5), .DATA_WIDTH(8)) dut_p (
    .clk(clk), .rst(rst),
    .w_wen(p_w_wen), .w_addr(p_w_addr), .w_data(p_w_data),
    .b_wen(p_b_wen), .b_addr(p_b_addr), .b_data(p_b_data),
    .x_wen(p_x_wen), .x_addr(p_x_addr), .x_data(p_x_data),
    .act_mode(p_act), .start(p_start),
    .busy(p_busy), .out_valid(p_out_valid), .out_idx(p_out_idx),
    .out_data(p_out_data), .class_idx(p_class), .done(p_done)
  );

  task automatic a_load(input int w[8], input int b0, input int b1, input int x[4]);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_w_wen = 1'b1; a_w_addr = 3'(k); a_w_data = 8'(w[k]);
      a_b_wen = (k < 2); a_b_addr = 1'(k); a_b_data = 8'((k == 0) ? b0 : b1);
      a_x_wen = (k < 4); a_x_addr = 2'(k); a_x_data = 8'(x[k % 4]);
    end
    @(negedge clk);
    a_w_wen = 1'b0; a_b_wen = 1'b0; a_x_wen = 1'b0;
  endtask

  // One evaluation on the 4x2 instance; optional start/write pokes while busy.
  task automatic run_a(input string name, input logic [1:0] mode, input int e0,
                       input int e1, input int ecls, input bit guard);
    int ve[2];
    int vd[2];
    int nv, nd, de, cls;
    ve = '{-1, -1}; vd = '{0, 0};
    nv = 0; nd = 0; de = -1; cls = -1;
    @(negedge clk);
    a_act = mode; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got=%b want=1", name, a_busy); end
      end
      if (a_out_valid) begin
        checks++;
        if (a_out_idx !== 1'(nv)) begin errors++; $display("FAIL %s out_idx got=%0d want=%0d", name, a_out_idx, nv); end
        if (nv < 2) begin ve[nv] = k; vd[nv] = int'(a_out_data); end
        nv++;
      end
      if (a_done) begin
        nd++; de = k; cls = int'(a_class);
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got=%b want=0", name, a_busy); end
      end
      if (guard && k == 2) a_start = 1'b1;
      if (guard && k == 3) begin
        a_start = 1'b0; a_w_wen = 1'b1; a_w_addr = 3'd4; a_w_data = 8'sd99;
      end
      if (guard && k == 4) a_w_wen = 1'b0;
    end
    checks++;
    if (nv !== 2) begin errors++; $display("FAIL %s strobe_count got=%0d want=2", name, nv); end
    checks++;
    if (ve[0] !== 5 || vd[0] !== e0)
      begin errors++; $display("FAIL %s neuron0 got=%0d@%0d want=%0d@5", name, vd[0], ve[0], e0); end
    checks++;
    if (ve[1] !== 10 || vd[1] !== e1)
      begin errors++; $display("FAIL %s neuron1 got=%0d@%0d want=%0d@10", name, vd[1], ve[1], e1); end
    checks++;
    if (nd !== 1 || de !== 11)
      begin errors++; $display("FAIL %s done count=%0d edge=%0d want 1 at 11", name, nd, de); end
    checks++;
    if (cls !== ecls) begin errors++; $display("FAIL %s class_idx got=%0d want=%0d", name, cls, ecls); end
    checks++;
    if (a_class !== 1'(ecls)) begin errors++; $display("FAIL %s class_hold got=%0d want=%0d", name, a_class, ecls); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_w_wen = 0; a_b_wen = 0; a_x_wen = 0; a_start = 0; a_act = 0;
    a_w_addr = 0; a_b_addr = 0; a_x_addr = 0; a_w_data = 0; a_b_data = 0; a_x_data = 0;
    p_w_wen = 0; p_b_wen = 0; p_x_wen = 0; p_start = 0; p_act = 0;
    p_w_addr = 0; p_b_addr = 0; p_x_addr = 0; p_w_data = 0; p_b_data = 0; p_x_data = 0;
    #1;
    checks++;
    if ({a_busy, a_out_valid, a_done} !== 3'b000)
      begin errors++; $display("FAIL reset_flags got=%b want=000", {a_busy, a_out_valid, a_done}); end
    checks++;
    if (a_out_data !== 16'sd0 || a_out_idx !== 1'b0 || a_class !== 1'b0)
      begin errors++; $display("FAIL reset_data got=%0d/%0d/%0d want=0/0/0", a_out_data, a_out_idx, a_class); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({p_busy, p_out_valid, p_done, p_class} !== 6'b0)
      begin errors++; $display("FAIL reset_p got=%b want=0", {p_busy, p_out_valid, p_done, p_class}); end
  endtask

  task automatic load_basic(input int b0, input int b1);
    a_load('{1, 2, 3, 4, -1, -1, -1, -1}, b0, b1, '{1, 1, 1, 1});
  endtask

  task automatic test_basic();
    load_basic(0, 0);
    run_a("linear", 2'd0, 10, -4, 0, 1'b0);
    run_a("reserved_mode", 2'd3, 10, -4, 0, 1'b0);
  endtask

  task automatic test_relu_step();
    load_basic(0, 20);
    run_a("relu_bias", 2'd1, 10, 16, 1, 1'b0);
    load_basic(-10, 0);
    run_a("step_tie", 2'd2, 0, 0, 0, 1'b0);
    run_a("relu_neg", 2'd1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    a_load('{-128, -128, -128, -128, -128, -128, -128, -128}, 127, 127,
           '{-128, -128, -128, -128});
    run_a("saturate", 2'd0, 32767, 32767, 0, 1'b0);
  endtask

  task automatic test_guard();
    load_basic(0, 0);
    run_a("guard", 2'd0, 10, -4, 0, 1'b1);
    run_a("guard_after", 2'd0, 10, -4, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    load_basic(0, 0);
    @(negedge clk);
    a_act = 2'd0; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 16'sd10)
      begin errors++; $display("FAIL midrun_first got=%b/%0d want=1/10", a_out_valid, a_out_data); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_out_valid, a_done} !== 3'b000 || a_out_data !== 16'sd0)
      begin errors++; $display("FAIL midrun_reset got=%b/%0d want=000/0", {a_busy, a_out_valid, a_done}, a_out_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0)
      begin errors++; $display("FAIL midrun_no_done got=%b/%b want=0/0", a_done, a_busy); end
    run_a("cleared_files", 2'd0, 0, 0, 0, 1'b0);
    load_basic(0, 20);
    run_a("after_reload", 2'd0, 10, 16, 1, 1'b0);
  endtask

  task automatic test_parametric();
    int w[15];
    int x[3];
    int b[5];
    int exp_v[5];
    int ve[5];
    int vd[5];
    int vi[5];
    int nv, nd, de, cls, ecls, best, s;
    for (int k = 0; k < 15; k++) w[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < 3; k++)  x[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < 5; k++)  b[k] = int'($urandom_range(0, 255)) - 128;
    w[0] = -128; x[0] = -128;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      p_w_wen = 1'b1; p_w_addr = 4'(k); p_w_data = 8'(w[k]);
      p_b_wen = (k < 5); p_b_addr = 3'(k); p_b_data = 8'(b[k % 5]);
      p_x_wen = (k < 3); p_x_addr = 2'(k); p_x_data = 8'(x[k % 3]);
    end
    @(negedge clk);
    p_w_wen = 1'b0; p_b_wen = 1'b0; p_x_wen = 1'b0;
    for (int m = 0; m < 4; m++) begin
      for (int j = 0; j < 5; j++) begin
        s = b[j];
        for (int i = 0; i < 3; i++) s += w[j*3+i] * x[i];
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (m == 1 && s < 0) s = 0;
        if (m == 2) s = (s > 0) ? 1 : 0;
        exp_v[j] = s;
      end
      best = exp_v[0]; ecls = 0;
      for (int j = 1; j < 5; j++) if (exp_v[j] > best) begin best = exp_v[j]; ecls = j; end
      for (int j = 0; j < 5; j++) begin ve[j] = -1; vd[j] = 0; vi[j] = -1; end
      nv = 0; nd = 0; de = -1; cls = -1;
      @(negedge clk);
      p_act = 2'(m); p_start = 1'b1;
      @(posedge clk); #1 p_start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (p_out_valid) begin
          if (nv < 5) begin ve[nv] = k; vd[nv] = int'(p_out_data); vi[nv] = int'(p_out_idx); end
          nv++;
        end
        if (p_done) begin nd++; de = k; cls = int'(p_class); end
      end
      checks++;
      if (nv !== 5) begin errors++; $display("FAIL param_m%0d strobes got=%0d want=5", m, nv); end
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (vd[j] !== exp_v[j] || ve[j] !== (j+1)*4 || vi[j] !== j)
          begin errors++; $display("FAIL param_m%0d n%0d got=%0d@%0d idx%0d want=%0d@%0d idx%0d",
                                   m, j, vd[j], ve[j], vi[j], exp_v[j], (j+1)*4, j); end
      end
      checks++;
      if (nd !== 1 || de !== 21 || cls !== ecls)
        begin errors++; $display("FAIL param_m%0d done n=%0d edge=%0d cls=%0d want 1/21/%0d",
                                 m, nd, de, cls, ecls); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_step();
    test_saturation();
    test_guard();
    test_reset_mid_run();
    test_parametric();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
